// File: rtl/axis_uart_rx.sv
// UART receiver: packs DATA_BYTE parity-checked characters (first one in the MSB) into one AXI4-Stream word.
// Define UART_RX_TIMEOUT_EN to drop a partial word after 16 idle bit-times between characters.
module axis_uart_rx #(
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned CLOCK          = 100_000_000,
  parameter int unsigned BAUD_RATE      = 115_200,
  parameter int unsigned DATA_BITS      = 8,
  parameter int unsigned STOP_BITS      = 1,
  parameter int unsigned PARITY_BITS    = 0
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic                      uart_rx,
  output logic                      rx_done,
  output logic                      parity_err,
  output logic                      frame_err,
  output logic                      overrun_err,
  output logic [AXI_DATA_WIDTH-1:0] m_axis_tdata,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready
);

  localparam int unsigned COUNT_SPEED = CLOCK / BAUD_RATE;
  localparam int unsigned HALF_SPEED  = COUNT_SPEED / 2;
  localparam int unsigned DATA_BYTE   = AXI_DATA_WIDTH / DATA_BITS;
  localparam int unsigned CNT_W       = $clog2(COUNT_SPEED + 1);
  localparam int unsigned BYTE_W      = $clog2(DATA_BYTE + 1);
  localparam int unsigned BIT_W       = $clog2(DATA_BITS + 1);
  localparam int unsigned STOP_W      = $clog2(STOP_BITS + 1);
  localparam int unsigned IDX_W       = $clog2(AXI_DATA_WIDTH);
`ifdef UART_RX_TIMEOUT_EN
  localparam int unsigned TIMEOUT     = 16 * COUNT_SPEED;
  localparam int unsigned TO_W        = $clog2(TIMEOUT + 1);
`endif

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                    state;
  logic                      rx_meta, rx_sync, rx_prev;
  logic [CNT_W-1:0]          count_baud;
  logic [BYTE_W-1:0]         count_byte;
  logic [BIT_W-1:0]          bit_cnt;
  logic [STOP_W-1:0]         stop_cnt;
  logic                      par_acc;
  logic [AXI_DATA_WIDTH-1:0] shift;
`ifdef UART_RX_TIMEOUT_EN
  logic [TO_W-1:0]           idle_cnt;
`endif

  logic             fall;
  logic             half_hit;
  logic             full_hit;
  logic             par_exp;
  logic             last_byte;
  logic [IDX_W-1:0] shift_idx;

  assign fall      = rx_prev & ~rx_sync;
  assign half_hit  = (count_baud == CNT_W'(HALF_SPEED - 1));
  assign full_hit  = (count_baud == CNT_W'(COUNT_SPEED - 1));
  assign par_exp   = (PARITY_BITS == 1) ? par_acc : ~par_acc;
  assign last_byte = (count_byte == BYTE_W'(DATA_BYTE - 1));
  assign shift_idx = IDX_W'(AXI_DATA_WIDTH - DATA_BITS + 32'(bit_cnt) - 32'(count_byte) * DATA_BITS);

  // Two-flop synchroniser plus one delay stage for falling-edge detection
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state         <= IDLE;
      count_baud    <= '0;
      count_byte    <= '0;
      bit_cnt       <= '0;
      stop_cnt      <= '0;
      par_acc       <= 1'b0;
      shift         <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      rx_done       <= 1'b0;
      parity_err    <= 1'b0;
      frame_err     <= 1'b0;
      overrun_err   <= 1'b0;
`ifdef UART_RX_TIMEOUT_EN
      idle_cnt      <= '0;
`endif
    end else begin
      rx_done     <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
      if (m_axis_tvalid && m_axis_tready) m_axis_tvalid <= 1'b0;

      case (state)
        IDLE: begin
          if (fall) begin
            count_baud <= '0;
            state      <= START;
          end
`ifdef UART_RX_TIMEOUT_EN
          if (fall) begin
            idle_cnt <= '0;
          end else if (count_byte != '0) begin
            if (idle_cnt == TO_W'(TIMEOUT - 1)) begin
              idle_cnt   <= '0;
              count_byte <= '0;
              frame_err  <= 1'b1;
            end else begin
              idle_cnt <= idle_cnt + TO_W'(1);
            end
          end
`endif
        end

        // A high line at mid start bit is a glitch; the partial word is kept
        START: begin
          if (half_hit) begin
            count_baud <= '0;
            if (!rx_sync) begin
              bit_cnt <= '0;
              par_acc <= 1'b0;
              state   <= DATA;
            end else begin
              state <= IDLE;
            end
          end else begin
            count_baud <= count_baud + CNT_W'(1);
          end
        end

        DATA: begin
          if (full_hit) begin
            count_baud       <= '0;
            shift[shift_idx] <= rx_sync;
            par_acc          <= par_acc ^ rx_sync;
            if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
              bit_cnt <= '0;
              state   <= PARITY;
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
            end
          end else begin
            count_baud <= count_baud + CNT_W'(1);
          end
        end

        PARITY: begin
          if (full_hit) begin
            count_baud <= '0;
            if (rx_sync != par_exp) parity_err <= 1'b1;
            stop_cnt <= '0;
            state    <= STOP;
          end else begin
            count_baud <= count_baud + CNT_W'(1);
          end
        end

        // Word completion loads the output register only if it is free or draining this cycle
        STOP: begin
          if (full_hit) begin
            count_baud <= '0;
            if (!rx_sync) begin
              frame_err  <= 1'b1;
              count_byte <= '0;
              stop_cnt   <= '0;
              state      <= IDLE;
            end else if (stop_cnt == STOP_W'(STOP_BITS - 1)) begin
              stop_cnt <= '0;
              state    <= IDLE;
              if (last_byte) begin
                count_byte <= '0;
                if (!m_axis_tvalid || m_axis_tready) begin
                  m_axis_tdata  <= shift;
                  m_axis_tvalid <= 1'b1;
                  rx_done       <= 1'b1;
                end else begin
                  overrun_err <= 1'b1;
                end
              end else begin
                count_byte <= count_byte + BYTE_W'(1);
              end
            end else begin
              stop_cnt <= stop_cnt + STOP_W'(1);
            end
          end else begin
            count_baud <= count_baud + CNT_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_uart_rx.sv
// Scoreboard bench for axis_uart_rx at 10 clocks per bit, odd parity, one stop bit.
module tb_axis_uart_rx;

  localparam int unsigned CS = 10;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        uart_rx = 1'b1;
  logic        tready = 1'b1;
  logic        rx_done, parity_err, frame_err, overrun_err;
  logic [31:0] tdata;
  logic        tvalid;

  axis_uart_rx #(
    .AXI_DATA_WIDTH(32), .CLOCK(1_000_000), .BAUD_RATE(100_000),
    .DATA_BITS(8), .STOP_BITS(1), .PARITY_BITS(0)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .uart_rx(uart_rx),
    .rx_done(rx_done), .parity_err(parity_err), .frame_err(frame_err),
    .overrun_err(overrun_err), .m_axis_tdata(tdata), .m_axis_tvalid(tvalid),
    .m_axis_tready(tready)
  );

  always #5 aclk = ~aclk;

  int n_cmp = 0;
  int n_err = 0;
  int n_done = 0, n_par = 0, n_frm = 0, n_ovr = 0, n_hs = 0;
  int s_done, s_par, s_frm, s_ovr, s_hs;
  int rd_idx = 0;
  logic [31:0] got_w [64];
  logic [31:0] exp_q [$];

  // Output monitor: pulse counters and accepted words
  always @(negedge aclk) begin
    if (aresetn) begin
      if (rx_done)     n_done++;
      if (parity_err)  n_par++;
      if (frame_err)   n_frm++;
      if (overrun_err) n_ovr++;
      if (tvalid && tready && n_hs < 64) begin
        got_w[n_hs] = tdata;
        n_hs++;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic snap();
    s_done = n_done; s_par = n_par; s_frm = n_frm; s_ovr = n_ovr; s_hs = n_hs;
  endtask

  task automatic drain();
    while (rd_idx < n_hs) begin
      if (exp_q.size() == 0) check_eq("sb_nonempty", 32'(exp_q.size()), 32'd1);
      else check_eq("word", got_w[rd_idx], exp_q.pop_front());
      rd_idx++;
    end
  endtask

  task automatic hold_bit(input logic v);
    uart_rx = v;
    repeat (CS) @(negedge aclk);
  endtask

  task automatic send_char(input logic [7:0] c, input bit bad_par, input bit bad_stop);
    @(negedge aclk);
    hold_bit(1'b0);
    for (int i = 0; i < 8; i++) hold_bit(c[i]);
    hold_bit((~^c) ^ bad_par);
    hold_bit(~bad_stop);
    hold_bit(1'b1);
  endtask

  task automatic send_word(input logic [31:0] w, input int bad_par_idx, input int bad_stop_idx);
    for (int k = 0; k < 4; k++)
      send_char(w[31-8*k -: 8], k == bad_par_idx, k == bad_stop_idx);
  endtask

  task automatic check_flags_idle(input string tag);
    check_eq({tag, "_done"},   32'(n_done - s_done), 32'd0);
    check_eq({tag, "_par"},    32'(n_par - s_par),   32'd0);
    check_eq({tag, "_frm"},    32'(n_frm - s_frm),   32'd0);
    check_eq({tag, "_ovr"},    32'(n_ovr - s_ovr),   32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_tvalid"}, 32'(tvalid), 32'd0);
    check_eq({tag, "_tdata"},  tdata, 32'd0);
    check_eq({tag, "_flags"},  32'({rx_done, parity_err, frame_err, overrun_err}), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge aclk);
    check_reset_outputs("reset");
    aresetn = 1'b1;
    repeat (5) @(negedge aclk);

    // Clean word
    snap();
    exp_q.push_back(32'hA53C01FF);
    send_word(32'hA53C01FF, -1, -1);
    repeat (20) @(negedge aclk);
    drain();
    check_eq("t1_done", 32'(n_done - s_done), 32'd1);
    check_eq("t1_hs",   32'(n_hs - s_hs),     32'd1);
    check_eq("t1_par",  32'(n_par - s_par),   32'd0);
    check_eq("t1_frm",  32'(n_frm - s_frm),   32'd0);
    check_eq("t1_ovr",  32'(n_ovr - s_ovr),   32'd0);

    // Bad parity on 2nd character; word still delivered
    snap();
    exp_q.push_back(32'hA53C01FF);
    send_word(32'hA53C01FF, 1, -1);
    repeat (20) @(negedge aclk);
    drain();
    check_eq("t2_par",  32'(n_par - s_par),   32'd1);
    check_eq("t2_done", 32'(n_done - s_done), 32'd1);
    check_eq("t2_frm",  32'(n_frm - s_frm),   32'd0);

    // Framing error discards the partial word
    snap();
    send_char(8'hA5, 1'b0, 1'b0);
    send_char(8'h3C, 1'b0, 1'b1);
    repeat (20) @(negedge aclk);
    check_eq("t3_frm",    32'(n_frm - s_frm),   32'd1);
    check_eq("t3_tvalid", 32'(tvalid),          32'd0);
    check_eq("t3_nodone", 32'(n_done - s_done), 32'd0);
    exp_q.push_back(32'h11223344);
    send_word(32'h11223344, -1, -1);
    repeat (20) @(negedge aclk);
    drain();
    check_eq("t3_done", 32'(n_done - s_done), 32'd1);

    // Overrun while output is stalled
    @(posedge aclk); #1 tready = 1'b0;
    snap();
    exp_q.push_back(32'hDEADBEEF);
    send_word(32'hDEADBEEF, -1, -1);
    repeat (20) @(negedge aclk);
    check_eq("t4_tvalid1", 32'(tvalid), 32'd1);
    check_eq("t4_tdata1",  tdata, 32'hDEADBEEF);
    send_word(32'h12345678, -1, -1);
    repeat (20) @(negedge aclk);
    check_eq("t4_ovr",    32'(n_ovr - s_ovr),   32'd1);
    check_eq("t4_done",   32'(n_done - s_done), 32'd1);
    check_eq("t4_tdata2", tdata, 32'hDEADBEEF);
    check_eq("t4_nohs",   32'(n_hs - s_hs),     32'd0);
    @(posedge aclk); #1 tready = 1'b1;
    repeat (3) @(negedge aclk);
    check_eq("t4_tvalid0", 32'(tvalid),      32'd0);
    check_eq("t4_hs",      32'(n_hs - s_hs), 32'd1);
    drain();

    // Short low glitch on the idle line
    snap();
    @(negedge aclk);
    uart_rx = 1'b0;
    repeat (3) @(negedge aclk);
    uart_rx = 1'b1;
    repeat (40) @(negedge aclk);
    check_flags_idle("t5_glitch");
    check_eq("t5_tvalid", 32'(tvalid), 32'd0);
    exp_q.push_back(32'hCAFEF00D);
    send_word(32'hCAFEF00D, -1, -1);
    repeat (20) @(negedge aclk);
    drain();
    check_eq("t5_done", 32'(n_done - s_done), 32'd1);
    check_eq("t5_err",  32'((n_par - s_par) + (n_frm - s_frm) + (n_ovr - s_ovr)), 32'd0);

    // Reset in the middle of the 3rd character's data bits
    send_char(8'h55, 1'b0, 1'b0);
    send_char(8'h66, 1'b0, 1'b0);
    @(negedge aclk);
    hold_bit(1'b0);
    hold_bit(1'b1);
    hold_bit(1'b1);
    hold_bit(1'b1);
    aresetn = 1'b0;
    uart_rx = 1'b1;
    repeat (2) @(negedge aclk);
    check_reset_outputs("t6_reset");
    aresetn = 1'b1;
    repeat (20) @(negedge aclk);
    snap();
    exp_q.push_back(32'h01020304);
    send_word(32'h01020304, -1, -1);
    repeat (20) @(negedge aclk);
    drain();
    check_eq("t6_done", 32'(n_done - s_done), 32'd1);
    check_eq("t6_err",  32'((n_par - s_par) + (n_frm - s_frm) + (n_ovr - s_ovr)), 32'd0);

    check_eq("sb_left", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
